// File: rtl/mvm_seq_ctrl.sv
// Address/enable sequencer for the single-MAC matrix-vector datapath.
// Loads A then x under ready/valid, runs K rows of K MACs, then streams y out.
module mvm_seq_ctrl #(
  parameter int unsigned K    = 8,
  parameter int unsigned LOGK = $clog2(K)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [2*LOGK-1:0] addr_a,
  output logic              wr_en_a,
  output logic [LOGK-1:0]   addr_x,
  output logic              wr_en_x,
  output logic [LOGK-1:0]   addr_y,
  output logic              wr_en_y,
  output logic              acc_clr,
  output logic              acc_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done,
  output logic              busy
);

  localparam int unsigned     AW     = 2 * LOGK;
  localparam logic [AW-1:0]   A_LAST = AW'(K * K - 1);
  localparam logic [LOGK-1:0] K_LAST = LOGK'(K - 1);

  typedef enum logic [2:0] {
    S_LOAD_A, S_LOAD_X, S_MAC, S_DRAIN, S_WR_Y, S_PRIME, S_OUT, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   a_cnt_q, a_cnt_d;
  logic [LOGK-1:0] x_cnt_q, x_cnt_d;
  logic [LOGK-1:0] row_q, row_d;
  logic [LOGK-1:0] col_q, col_d;
  logic            drain_q, drain_d;
  logic            iss_q, iss_d;
  logic            acc_en_q, acc_en_d;
  logic [AW-1:0]   addr_a_q, addr_a_d;
  logic [LOGK-1:0] addr_x_q, addr_x_d;
  logic [LOGK-1:0] addr_y_q, addr_y_d;
  logic            wr_en_y_q, wr_en_y_d;
  logic            acc_clr_q, acc_clr_d;
  logic            out_valid_q, out_valid_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  // Write strobes must coincide with the data word, so they follow in_valid directly.
  assign in_ready = !reset && (state_q == S_LOAD_A || state_q == S_LOAD_X);
  assign wr_en_a  = in_ready && in_valid && (state_q == S_LOAD_A);
  assign wr_en_x  = in_ready && in_valid && (state_q == S_LOAD_X);

  assign addr_a    = addr_a_q;
  assign addr_x    = addr_x_q;
  assign addr_y    = addr_y_q;
  assign wr_en_y   = wr_en_y_q;
  assign acc_clr   = acc_clr_q;
  assign acc_en    = acc_en_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign busy      = busy_q;

  always_comb begin
    state_d  = state_q;
    a_cnt_d  = a_cnt_q;
    x_cnt_d  = x_cnt_q;
    row_d    = row_q;
    col_d    = col_q;
    drain_d  = 1'b0;
    addr_y_d = addr_y_q;

    case (state_q)
      S_LOAD_A: begin
        if (in_valid) begin
          if (a_cnt_q == A_LAST) begin
            a_cnt_d = '0;
            state_d = S_LOAD_X;
          end else begin
            a_cnt_d = a_cnt_q + AW'(1);
          end
        end
      end
      S_LOAD_X: begin
        if (in_valid) begin
          if (x_cnt_q == K_LAST) begin
            x_cnt_d = '0;
            row_d   = '0;
            col_d   = '0;
            state_d = S_MAC;
          end else begin
            x_cnt_d = x_cnt_q + LOGK'(1);
          end
        end
      end
      S_MAC: begin
        addr_y_d = row_q;
        if (col_q == K_LAST) state_d = S_DRAIN;
        else                 col_d   = col_q + LOGK'(1);
      end
      // Two cycles let the last product reach the accumulator.
      S_DRAIN: begin
        drain_d = !drain_q;
        if (drain_q) state_d = S_WR_Y;
      end
      S_WR_Y: begin
        if (row_q == K_LAST) begin
          addr_y_d = '0;
          state_d  = S_PRIME;
        end else begin
          row_d   = row_q + LOGK'(1);
          col_d   = '0;
          state_d = S_MAC;
        end
      end
      S_PRIME: state_d = S_OUT;
      S_OUT: begin
        if (out_ready) begin
          if (addr_y_q == K_LAST) begin
            state_d = S_DONE;
          end else begin
            addr_y_d = addr_y_q + LOGK'(1);
            state_d  = S_PRIME;
          end
        end
      end
      S_DONE: begin
        a_cnt_d  = '0;
        x_cnt_d  = '0;
        row_d    = '0;
        col_d    = '0;
        addr_y_d = '0;
        state_d  = S_LOAD_A;
      end
    endcase

    // Registered outputs are derived from the next state so they align with it.
    addr_a_d = addr_a_q;
    addr_x_d = addr_x_q;
    case (state_d)
      S_LOAD_A: addr_a_d = a_cnt_d;
      S_LOAD_X: addr_x_d = x_cnt_d;
      S_MAC: begin
        addr_a_d = AW'(row_d) * AW'(K) + AW'(col_d);
        addr_x_d = col_d;
      end
      default: ;
    endcase

    iss_d       = (state_q == S_MAC);
    acc_en_d    = iss_q;
    wr_en_y_d   = (state_d == S_WR_Y);
    acc_clr_d   = (state_d == S_LOAD_A) || (state_d == S_LOAD_X) || (state_d == S_WR_Y);
    out_valid_d = (state_d == S_OUT);
    done_d      = (state_d == S_DONE);
    busy_d      = !((state_d == S_LOAD_A) && (a_cnt_d == '0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LOAD_A;
      a_cnt_q     <= '0;
      x_cnt_q     <= '0;
      row_q       <= '0;
      col_q       <= '0;
      drain_q     <= 1'b0;
      iss_q       <= 1'b0;
      acc_en_q    <= 1'b0;
      addr_a_q    <= '0;
      addr_x_q    <= '0;
      addr_y_q    <= '0;
      wr_en_y_q   <= 1'b0;
      acc_clr_q   <= 1'b1;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_cnt_q     <= a_cnt_d;
      x_cnt_q     <= x_cnt_d;
      row_q       <= row_d;
      col_q       <= col_d;
      drain_q     <= drain_d;
      iss_q       <= iss_d;
      acc_en_q    <= acc_en_d;
      addr_a_q    <= addr_a_d;
      addr_x_q    <= addr_x_d;
      addr_y_q    <= addr_y_d;
      wr_en_y_q   <= wr_en_y_d;
      acc_clr_q   <= acc_clr_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_mvm_seq_ctrl.sv
// Bench for mvm_seq_ctrl at K=4: behavioural memories/MAC around the sequencer,
// results compared against a plain matrix-vector product and the row schedule.
module tb_mvm_seq_ctrl;

  localparam int K   = 4;
  localparam int KK  = K * K;
  localparam int KK3 = K * (K + 3);

  logic           clk;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [3:0]     addr_a;
  logic           wr_en_a;
  logic [1:0]     addr_x;
  logic           wr_en_x;
  logic [1:0]     addr_y;
  logic           wr_en_y;
  logic           acc_clr;
  logic           acc_en;
  logic           out_valid;
  logic           out_ready;
  logic           done;
  logic           busy;

  int data_in;

  mvm_seq_ctrl #(.K(K)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .addr_a(addr_a), .wr_en_a(wr_en_a), .addr_x(addr_x), .wr_en_x(wr_en_x),
    .addr_y(addr_y), .wr_en_y(wr_en_y), .acc_clr(acc_clr), .acc_en(acc_en),
    .out_valid(out_valid), .out_ready(out_ready), .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath around the sequencer: registered reads, product register, accumulator.
  int a_mem [KK];
  int x_mem [K];
  int y_mem [K];
  int a_rd, x_rd, prod, acc, y_rd;

  always @(posedge clk) begin
    if (wr_en_a) a_mem[addr_a] <= data_in;
    if (wr_en_x) x_mem[addr_x] <= data_in;
    if (wr_en_y) y_mem[addr_y] <= acc;
    a_rd <= a_mem[addr_a];
    x_rd <= x_mem[addr_x];
    prod <= a_rd * x_rd;
    if (acc_clr)     acc <= 0;
    else if (acc_en) acc <= acc + prod;
    y_rd <= y_mem[addr_y];
  end

  int checks = 0;
  int errors = 0;

  int a_in [KK];
  int x_in [K];
  int ref_y [K];

  int cyc_n = 0;
  bit mon_en = 1'b0;
  bit loading;
  int n_wa, n_wx, n_out;
  int job_wa, job_wx, job_done;
  int last_x_cyc;
  bit prev_stall, prev_last_hs;
  int prev_addr_y, prev_y;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  // Per-cycle expectations derived from the load/compute/output rules.
  task automatic observe();
    bit rdy_e, wa_e, wx_e, hs, last_hs;
    int t, r, p;
    if (!mon_en) return;
    rdy_e = loading && !reset;
    wa_e  = rdy_e && in_valid && (n_wa < KK);
    wx_e  = rdy_e && in_valid && (n_wa == KK);
    chk("in_ready", in_ready, rdy_e);
    chk("wr_en_a", wr_en_a, wa_e);
    chk("wr_en_x", wr_en_x, wx_e);
    chk("busy", busy, !(loading && n_wa == 0));
    if (loading) begin
      chk("acc_clr_load", acc_clr, 1);
      chk("out_valid_load", out_valid, 0);
    end
    if (wa_e) begin
      chk("addr_a_load", addr_a, n_wa);
      n_wa++;
      job_wa++;
    end
    if (wx_e) begin
      chk("addr_x_load", addr_x, n_wx);
      n_wx++;
      job_wx++;
      if (n_wx == K) begin
        loading    = 1'b0;
        last_x_cyc = cyc_n;
      end
    end
    if (last_x_cyc >= 0 && !loading) begin
      t = cyc_n - last_x_cyc;
      if (t >= 1 && t <= KK3) begin
        r = (t - 1) / (K + 3);
        p = (t - 1) % (K + 3);
        chk("acc_en", acc_en, (p >= 2) && (p <= K + 1));
        chk("wr_en_y", wr_en_y, p == K + 2);
        chk("acc_clr_mac", acc_clr, p == K + 2);
        if (p == K + 2) chk("addr_y_wr", addr_y, r);
        if (p < K) begin
          chk("addr_a_mac", addr_a, r * K + p);
          chk("addr_x_mac", addr_x, p);
        end
      end
      if (t == KK3 + 1) chk("prime_out_valid", out_valid, 0);
      if (t == KK3 + 2) chk("first_out_valid", out_valid, 1);
    end
    if (prev_stall) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_addr", addr_y, prev_addr_y);
      chk("stall_data", y_rd, prev_y);
    end
    hs      = out_valid && out_ready;
    last_hs = hs && (n_out == K - 1);
    chk("done", done, prev_last_hs);
    if (done) job_done++;
    if (prev_last_hs) begin
      loading    = 1'b1;
      n_wa       = 0;
      n_wx       = 0;
      last_x_cyc = -1;
    end
    if (hs) begin
      if (n_out < K) begin
        chk("y_value", y_rd, ref_y[n_out]);
        chk("y_addr", addr_y, n_out);
      end else begin
        chk("extra_output", out_valid, 0);
      end
      n_out++;
    end
    prev_stall   = out_valid && !out_ready;
    prev_addr_y  = int'(addr_y);
    prev_y       = y_rd;
    prev_last_hs = last_hs;
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    mon_en       = 1'b1;
    loading      = 1'b1;
    n_wa         = 0;
    n_wx         = 0;
    last_x_cyc   = -1;
    prev_stall   = 1'b0;
    prev_last_hs = 1'b0;
    chk("rst_acc_clr", acc_clr, 1);
    chk("rst_acc_en", acc_en, 0);
    chk("rst_wr_en_y", wr_en_y, 0);
    chk("rst_wr_en_a", wr_en_a, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr_a", addr_a, 0);
    chk("rst_addr_y", addr_y, 0);
    tick();
    reset = 1'b0;
  endtask

  task automatic fill_count();
    for (int i = 0; i < KK; i++) a_in[i] = i + 1;
    for (int j = 0; j < K; j++) x_in[j] = 1;
  endtask

  task automatic fill_ident();
    for (int i = 0; i < KK; i++) a_in[i] = ((i / K) == (i % K)) ? 1 : 0;
    x_in[0] = -3; x_in[1] = 5; x_in[2] = 0; x_in[3] = 7;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < KK; i++) a_in[i] = int'($urandom_range(0, 200)) - 100;
    for (int j = 0; j < K; j++) x_in[j] = int'($urandom_range(0, 200)) - 100;
  endtask

  // gap_mode: 0 none, 1 toggle, 2 random; rdy_mode: 0 always, 1 random, 2 stall 10 at first result.
  task automatic run_job(input int gap_mode, input int rdy_mode, input bit hold_iv, input int abort_t);
    int g, budget, stall_left;
    for (int i = 0; i < K; i++) begin
      ref_y[i] = 0;
      for (int j = 0; j < K; j++) ref_y[i] += a_in[i * K + j] * x_in[j];
    end
    n_out = 0; job_wa = 0; job_wx = 0; job_done = 0;
    stall_left = 10;
    for (int w = 0; w < KK + K; w++) begin
      if (gap_mode == 1 && w > 0) begin
        in_valid = 1'b0; data_in = int'($urandom); tick();
      end
      if (gap_mode == 2) begin
        g = int'($urandom_range(0, 2));
        repeat (g) begin
          in_valid = 1'b0; data_in = int'($urandom); tick();
        end
      end
      in_valid  = 1'b1;
      data_in   = (w < KK) ? a_in[w] : x_in[w - KK];
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    budget = 0;
    while (job_done == 0 && budget < 2000) begin
      if (abort_t > 0 && last_x_cyc >= 0 && (cyc_n - last_x_cyc) == abort_t) begin
        apply_reset();
        return;
      end
      in_valid = hold_iv;
      data_in  = int'($urandom);
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (out_valid && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
      tick();
      budget++;
    end
    in_valid = 1'b0;
    chk("job_completed", job_done, 1);
    chk("job_a_writes", job_wa, KK);
    chk("job_x_writes", job_wx, K);
    chk("job_outputs", n_out, K);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = 0;
    apply_reset();

    fill_count(); run_job(0, 0, 1'b0, 0);
    fill_count(); run_job(1, 0, 1'b0, 0);
    fill_ident(); run_job(2, 1, 1'b0, 0);
    fill_rand();  run_job(0, 2, 1'b0, 0);
    fill_rand();  run_job(2, 1, 1'b0, 2 * (K + 3) + 2);
    fill_rand();  run_job(2, 1, 1'b0, 0);
    fill_rand();  run_job(0, 1, 1'b1, 0);
    fill_rand();  run_job(1, 1, 1'b1, 0);
    for (int n = 0; n < 3; n++) begin
      fill_rand(); run_job(2, 1, 1'b0, 0);
    end
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
